// File: rtl/wb_dcache_flush_walker.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dcache_flush_walker
//  Description : Whole-cache flush and post-reset tag-initialisation sequencer
//                for the write-back data cache. It walks every set, writes
//                back each valid-and-dirty line, invalidates the set and
//                signals completion with a one-cycle acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dcache_flush_walker #(
    parameter int unsigned NR_SETS = 256,
    parameter int unsigned NR_WAYS = 8,
    parameter int unsigned TAG_W   = 44,
    parameter int unsigned IDX_W   = $clog2(NR_SETS),
    localparam int unsigned WAY_W  = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    // flush controller side
    input  logic                       flush_i,
    output logic                       flush_ack_o,
    input  logic                       init_ni,
    output logic                       busy_o,
    // tag-array arbiter side
    output logic                       tag_req_o,
    output logic                       tag_we_o,
    output logic [IDX_W-1:0]           tag_idx_o,
    input  logic                       tag_gnt_i,
    input  logic [NR_WAYS-1:0]         tag_valid_i,
    input  logic [NR_WAYS-1:0]         tag_dirty_i,
    input  logic [NR_WAYS*TAG_W-1:0]   tag_rdata_i,
    // write-back arbiter side
    output logic                       wb_req_o,
    output logic [WAY_W-1:0]           wb_way_o,
    output logic [IDX_W-1:0]           wb_idx_o,
    output logic [TAG_W-1:0]           wb_tag_o,
    input  logic                       wb_gnt_i,
    input  logic                       wb_done_i
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NR_SETS - 1);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_INIT    = 4'd1,
        S_IDLE    = 4'd2,
        S_READ    = 4'd3,
        S_WAIT_RD = 4'd4,
        S_SCAN    = 4'd5,
        S_WB      = 4'd6,
        S_WB_WAIT = 4'd7,
        S_CLEAR   = 4'd8,
        S_ACK     = 4'd9,
        S_COOL    = 4'd10
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NR_WAYS-1:0]         pend_q, pend_d;
    logic [NR_WAYS*TAG_W-1:0]   tags_q, tags_d;
    logic [WAY_W-1:0]           way_q, way_d;
    logic [TAG_W-1:0]           wb_tag_q, wb_tag_d;

    // Registered Moore outputs, loaded from the next state
    logic                       tag_req_q;
    logic                       tag_we_q;
    logic                       wb_req_q;
    logic                       ack_q;
    logic                       busy_q;

    logic [WAY_W-1:0]           w_lo_way;
    logic [TAG_W-1:0]           w_lo_tag;

    // Lowest pending way: scan from the top so the smallest index wins
    always_comb begin
        w_lo_way = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (pend_q[w]) begin
                w_lo_way = WAY_W'(w);
            end
        end
    end

    // Tag of the selected way, captured together with the way in SCAN
    always_comb begin
        w_lo_tag = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (w_lo_way == WAY_W'(w)) begin
                w_lo_tag = tags_q[w*TAG_W +: TAG_W];
            end
        end
    end

    // Next-state and datapath-update decode for the walker
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        tags_d   = tags_q;
        way_d    = way_q;
        wb_tag_d = wb_tag_q;

        case (state_q)
            S_RST: begin
                idx_d   = '0;
                state_d = init_ni ? S_IDLE : S_INIT;
            end

            S_INIT: begin
                if (tag_gnt_i) begin
                    if (idx_q == C_LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_IDLE: begin
                if (flush_i) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end

            S_READ: begin
                if (tag_gnt_i) begin
                    state_d = S_WAIT_RD;
                end
            end

            // Read data arrives exactly one cycle after the grant
            S_WAIT_RD: begin
                pend_d  = tag_valid_i & tag_dirty_i;
                tags_d  = tag_rdata_i;
                state_d = S_SCAN;
            end

            S_SCAN: begin
                if (pend_q != '0) begin
                    way_d    = w_lo_way;
                    wb_tag_d = w_lo_tag;
                    state_d  = S_WB;
                end else begin
                    state_d = S_CLEAR;
                end
            end

            S_WB: begin
                if (wb_gnt_i) begin
                    state_d = S_WB_WAIT;
                end
            end

            // Done is only honoured here, never in the grant cycle
            S_WB_WAIT: begin
                if (wb_done_i) begin
                    pend_d[way_q] = 1'b0;
                    state_d       = S_SCAN;
                end
            end

            S_CLEAR: begin
                if (tag_gnt_i) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = S_ACK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end

            S_ACK: begin
                idx_d   = '0;
                state_d = S_COOL;
            end

            // The controller's flush level is still high here; ignore it
            S_COOL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_RST;
            end
        endcase
    end

    // State, datapath and registered-output update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_RST;
            idx_q     <= '0;
            pend_q    <= '0;
            tags_q    <= '0;
            way_q     <= '0;
            wb_tag_q  <= '0;
            tag_req_q <= 1'b0;
            tag_we_q  <= 1'b0;
            wb_req_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            tags_q    <= tags_d;
            way_q     <= way_d;
            wb_tag_q  <= wb_tag_d;
            tag_req_q <= (state_d == S_INIT) || (state_d == S_READ) ||
                         (state_d == S_CLEAR);
            tag_we_q  <= (state_d == S_INIT) || (state_d == S_CLEAR);
            wb_req_q  <= (state_d == S_WB);
            ack_q     <= (state_d == S_ACK);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign flush_ack_o = ack_q;
    assign busy_o      = busy_q;
    assign tag_req_o   = tag_req_q;
    assign tag_we_o    = tag_we_q;
    assign tag_idx_o   = idx_q;
    assign wb_req_o    = wb_req_q;
    assign wb_way_o    = way_q;
    assign wb_idx_o    = idx_q;
    assign wb_tag_o    = wb_tag_q;

endmodule
`default_nettype wire
